// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scanner with debounce and two-digit key history
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic [3:0]    cap_col;
  logic [1:0]    state;
  logic [1:0]    row_idx;
  logic [CW-1:0] cnt;
  logic          col_onehot;
  logic [3:0]    cap_code;

  // Translate a (row, one-hot column) pair into the keypad's printed legend.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [3:0] c);
    logic [1:0] ci;
    ci = 2'd0;
    case (c)
      4'b0010: ci = 2'd1;
      4'b0100: ci = 2'd2;
      4'b1000: ci = 2'd3;
      default: ci = 2'd0;
    endcase
    case ({r, ci})
      4'b00_00: map_key = 4'h1;
      4'b00_01: map_key = 4'h2;
      4'b00_10: map_key = 4'h3;
      4'b00_11: map_key = 4'hA;
      4'b01_00: map_key = 4'h4;
      4'b01_01: map_key = 4'h5;
      4'b01_10: map_key = 4'h6;
      4'b01_11: map_key = 4'hB;
      4'b10_00: map_key = 4'h7;
      4'b10_01: map_key = 4'h8;
      4'b10_10: map_key = 4'h9;
      4'b10_11: map_key = 4'hC;
      4'b11_00: map_key = 4'hE;
      4'b11_01: map_key = 4'h0;
      4'b11_10: map_key = 4'hF;
      default:  map_key = 4'hD;
    endcase
  endfunction

  assign row        = 4'b0001 << row_idx;
  assign col_onehot = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);
  assign cap_code   = map_key(row_idx, cap_col);

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_m <= 4'd0;
      col_s <= 4'd0;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  // Scan / debounce / hold / release sequencer; row stays frozen outside SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      cnt       <= '0;
      cap_col   <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      digit_new <= 4'd0;
      digit_old <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (col_onehot) begin
              cap_col <= col_s;
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s != cap_col) begin
            state   <= ST_SCAN;
            row_idx <= row_idx + 2'd1;
            cnt     <= '0;
          end else if (cnt == DEB_LAST) begin
            key_valid <= 1'b1;
            key_code  <= cap_code;
            digit_new <= cap_code;
            digit_old <= digit_new;
            state     <= ST_HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (col_s == 4'd0) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end
        end
        default: begin
          if (col_s != 4'd0) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= ST_SCAN;
            row_idx <= row_idx + 2'd1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic [15:0] pressed = 16'd0;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  keypad_scan_ctrl #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_valid(key_valid),
    .key_code(key_code), .digit_new(digit_new), .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column only while its row is driven.
  function automatic logic [3:0] row_bits(input logic [15:0] p, input logic [3:0] r);
    case (r)
      4'b0001: row_bits = p[3:0];
      4'b0010: row_bits = p[7:4];
      4'b0100: row_bits = p[11:8];
      4'b1000: row_bits = p[15:12];
      default: row_bits = 4'd0;
    endcase
  endfunction

  assign col = row_bits(pressed, row);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed-time phases, key history kept as a queue.
  typedef enum int {P_SCAN, P_DEB, P_HELD, P_REL} phase_t;
  phase_t     ph = P_SCAN;
  int         ridx = 0;
  int         in_phase = 0;
  logic [3:0] sync_q [2];
  logic [3:0] cap = 4'd0;
  logic [3:0] accepted [$];
  logic       exp_valid = 1'b0;
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  function automatic logic [3:0] exp_nth(input int back);
    if (accepted.size() > back) exp_nth = accepted[accepted.size() - 1 - back];
    else exp_nth = 4'd0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] cs;
    if (reset) begin
      ph = P_SCAN; ridx = 0; in_phase = 0; cap = 4'd0; exp_valid = 1'b0;
      sync_q[0] = 4'd0; sync_q[1] = 4'd0;
      accepted.delete();
    end else begin
      cs = sync_q[1];
      sync_q[1] = sync_q[0];
      sync_q[0] = col;
      exp_valid = 1'b0;
      case (ph)
        P_SCAN: begin
          if (in_phase + 1 == SCAN) begin
            in_phase = 0;
            if ($countones(cs) == 1) begin cap = cs; ph = P_DEB; end
            else ridx = (ridx + 1) % 4;
          end else in_phase++;
        end
        P_DEB: begin
          if (cs != cap) begin ph = P_SCAN; ridx = (ridx + 1) % 4; in_phase = 0; end
          else if (in_phase + 1 == DEB) begin
            exp_valid = 1'b1;
            accepted.push_back(kmap[ridx * 4 + $clog2(cap)]);
            ph = P_HELD; in_phase = 0;
          end else in_phase++;
        end
        P_HELD: begin
          if (cs == 4'd0) begin ph = P_REL; in_phase = 0; end
        end
        default: begin
          if (cs != 4'd0) begin ph = P_HELD; in_phase = 0; end
          else if (in_phase + 1 == DEB) begin ph = P_SCAN; ridx = (ridx + 1) % 4; in_phase = 0; end
          else in_phase++;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("row", {28'd0, row}, {28'd0, 4'b0001 << ridx});
    check("key_valid", {31'd0, key_valid}, {31'd0, exp_valid});
    check("key_code", {28'd0, key_code}, {28'd0, exp_nth(0)});
    check("digit_new", {28'd0, digit_new}, {28'd0, exp_nth(0)});
    check("digit_old", {28'd0, digit_old}, {28'd0, exp_nth(1)});
    if (key_valid === 1'b1) pulses++;
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_deb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      clk_n(1);
      if (ph == P_DEB) ok = 1'b1;
    end
    check("deb_entry_within_budget", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int p0;
    bit ok;
    clk_n(3);
    check("reset_row", {28'd0, row}, 32'h1);
    check("reset_outs", {19'd0, key_valid, key_code, digit_new, digit_old}, 32'd0);

    // Idle scanning: row advances every SCAN clocks and wraps.
    reset = 1'b0;
    clk_n(3);
    check("row_hold_3", {28'd0, row}, 32'h1);
    clk_n(1);
    check("row_after_4", {28'd0, row}, 32'h2);
    clk_n(12);
    check("row_after_16", {28'd0, row}, 32'h1);
    check("idle_no_pulse", pulses, 0);

    // Key '5' held long: one event, row frozen while held.
    pressed = 16'h0020;
    clk_n(100);
    check("k5_pulses", pulses, 1);
    check("k5_code", {28'd0, key_code}, 32'h5);
    check("k5_new", {28'd0, digit_new}, 32'h5);
    check("k5_old", {28'd0, digit_old}, 32'h0);
    check("k5_row_frozen", {28'd0, row}, 32'h2);
    pressed = 16'h0000;
    clk_n(3);
    check("k5_row_after_release", {28'd0, row}, 32'h2);
    clk_n(40);

    // Press bounce then stable, then release bounce.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      clk_n(3);
    end
    check("bounce_no_pulse", pulses - p0, 0);
    pressed = 16'h0020;
    clk_n(60);
    check("bounce_one_pulse", pulses - p0, 1);
    check("bounce_code", {28'd0, key_code}, 32'h5);
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'h0000 : 16'h0020;
      clk_n(3);
    end
    pressed = 16'h0000;
    clk_n(40);
    check("release_bounce_no_pulse", pulses - p0, 1);

    // '7' then 'A'.
    p0 = pulses;
    pressed = 16'h0100; clk_n(60);
    pressed = 16'h0000; clk_n(40);
    pressed = 16'h0008; clk_n(60);
    pressed = 16'h0000; clk_n(40);
    check("two_keys_pulses", pulses - p0, 2);
    check("two_keys_new", {28'd0, digit_new}, 32'hA);
    check("two_keys_old", {28'd0, digit_old}, 32'h7);

    // Multi-hot in one row is ignored; added column while held is ignored.
    p0 = pulses;
    pressed = 16'h0030; clk_n(60);
    check("multihot_no_pulse", pulses - p0, 0);
    pressed = 16'h0020; clk_n(60);
    pressed = 16'h0060; clk_n(40);
    check("added_col_one_pulse", pulses - p0, 1);
    check("added_col_code", {28'd0, key_code}, 32'h5);
    pressed = 16'h0000; clk_n(40);

    // Reset on the 5th and on the terminal DEBOUNCE cycle of key '9'.
    for (int t = 0; t < 2; t++) begin
      p0 = pulses;
      pressed = 16'h0400;
      wait_deb(ok);
      if (ok) begin
        clk_n(t == 0 ? 4 : 7);
        reset = 1'b1;
        clk_n(1);
        check("deb_reset_row", {28'd0, row}, 32'h1);
        check("deb_reset_outs", {19'd0, key_valid, key_code, digit_new, digit_old}, 32'd0);
        pressed = 16'h0000;
        clk_n(2);
        reset = 1'b0;
        clk_n(30);
        check("deb_reset_no_pulse", pulses - p0, 0);
      end
      pressed = 16'h0000;
      reset = 1'b0;
      clk_n(20);
    end

    // Randomized presses, bounces, extra keys and occasional resets.
    for (int it = 0; it < 40; it++) begin
      int k;
      k = $urandom_range(0, 15);
      repeat ($urandom_range(0, 3)) begin
        pressed = 16'h0001 << k; clk_n($urandom_range(1, 6));
        pressed = 16'h0000; clk_n($urandom_range(1, 6));
      end
      pressed = 16'h0001 << k;
      if ($urandom_range(0, 3) == 0) pressed = pressed | (16'h0001 << $urandom_range(0, 15));
      clk_n($urandom_range(0, 45));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1; clk_n($urandom_range(1, 3)); reset = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        pressed = 16'h0000; clk_n($urandom_range(1, 6));
        pressed = 16'h0001 << k; clk_n($urandom_range(1, 6));
      end
      pressed = 16'h0000;
      clk_n($urandom_range(0, 35));
    end
    clk_n(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences a 4x4 matrix keypad.
- Drives one-hot row strobes and synchronizes the asynchronous column inputs.
- Debounces press and release, and emits exactly one validated key event per physical press.
- Maintains the two-digit history (newest, previous) that feeds the two-digit multiplexed 7-segment display path.

Parameters:
SCAN_CYCLES, 4800, clocks each row is driven before advancing; minimum 3.
DEBOUNCE_CYCLES, 240000, clocks a press or release must be stable to be accepted; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
col  input  4  keypad columns, asynchronous, active-high (1 = key pressed in driven row)
row  output  4  one-hot active-high row drive
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  hex code of the last accepted key
digit_new  output  4  most recent accepted key
digit_old  output  4  key accepted before digit_new

Behaviour:
- Synchronizer: col passes through a 2-flop synchronizer to give col_s (2-cycle latency). All decisions use col_s only.
- Reset values: state=SCAN, row_idx=0 (row=4'b0001), dwell/debounce counters=0, key_valid=0, key_code=0, digit_new=0, digit_old=0, synchronizer flops=0, captured column=0.
- row = 1 << row_idx at all times; never all-zero, never multi-hot.
- Key map (row_idx, column bit to code):
  - r0: c0=1, c1=2, c2=3, c3=A
  - r1: c0=4, c1=5, c2=6, c3=B
  - r2: c0=7, c1=8, c2=9, c3=C
  - r3: c0=E, c1=0, c2=F, c3=D
- SCAN:
  - The dwell counter counts 0..SCAN_CYCLES-1.
  - On the terminal count, col_s is sampled. This is the settle window after the row change.
  - If col_s is one-hot: capture col_s and row_idx, clear the counter, go to DEBOUNCE. row stays frozen.
  - If col_s is zero or multi-hot: row_idx advances (3 wraps to 0) and the counter clears. Multi-hot is ignored, not an error.
- DEBOUNCE:
  - row is frozen and the counter increments each cycle.
  - If col_s != captured column in any cycle: abandon, go to SCAN, advance row_idx, clear the counter. No event.
  - If the counter reaches DEBOUNCE_CYCLES-1 with col_s == captured column:
    - next cycle key_valid=1 (for exactly one cycle);
    - key_code = mapped code;
    - digit_old <= digit_new, digit_new <= code;
    - go to HELD.
- HELD:
  - row is frozen. Any col_s nonzero value, including added columns in the same row, is ignored.
  - Keys in other rows are invisible because their rows are not driven.
  - When col_s == 0: clear the counter and go to RELEASE.
- RELEASE:
  - The counter increments while col_s == 0.
  - Any nonzero col_s: return to HELD with no new event. This is release bounce.
  - Counter reaches DEBOUNCE_CYCLES-1: go to SCAN, advance row_idx, clear the counter.
- Outputs key_code, digit_new and digit_old hold their values until the next accepted press.
- Latency from a stable press to key_valid is at most 2 + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 clocks.
- Reset has priority over everything. Reset asserted in any state, including mid-DEBOUNCE on the terminal cycle, gives all reset values on the next edge and no key_valid.
- Counter widths are sized by $clog2 of the larger parameter. Counters never wrap past their terminal value.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
- Reset with col=0: row=0001, all outputs 0. Row becomes 0010 after 4 clocks and is back to 0001 after 16 clocks; key_valid never asserts.
- Key '5' (col=0010 whenever row=0010) held 100 clocks: exactly one key_valid pulse, key_code=5, digit_new=5, digit_old=0. row stays 0010 until release, and scanning resumes 8 stable-release clocks after release.
- Bounce: col toggles 0010/0000 every 3 clocks for 30 clocks, then holds stable: no pulse during bouncing, then exactly one pulse with key_code=5. Release bounce produces no second pulse.
- Press '7' then release, then press 'A': digit_new=A and digit_old=7 after the second pulse; exactly two pulses total.
- col=0011 in row 1 gives no pulse and scanning continues. Separately, while '5' is HELD, assert col bit 2 as well: no additional pulse.
- Reset asserted on the 5th DEBOUNCE cycle of key '9': next cycle row=0001, all outputs 0, and key_valid never asserts for that press.
